// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_signed_a(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Radix-2 iterative RV32M multiply/divide unit: one bit per clock over magnitudes,
// sign fix-up in a final cycle, early-out for divide-by-zero and signed overflow.
module mdu_iterative #(
  parameter int unsigned XLEN = mdu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out
);
  import mdu_pkg::*;

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Datapath helpers shared by CALC and FIX
  mdu_op_e           op_in;
  logic              sa_in, sb_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    op_in = mdu_op_e'(op);
    sa_in = is_signed_a(op_in) & rs1_data[XLEN-1];
    sb_in = is_signed_b(op_in) & rs2_data[XLEN-1];
    mag_a = sa_in ? (~rs1_data + 1'b1) : rs1_data;
    mag_b = sb_in ? (~rs2_data + 1'b1) : rs2_data;

    // Multiply: multiplier in the low half shifts out as the product shifts in.
    mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q})
                        : {1'b0, acc_q[2*XLEN-1:XLEN]};
    mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: remainder in the high half, dividend/quotient in the low half.
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, b_q};
    div_step = {(div_diff[XLEN] ? rem_sh[XLEN-1:0] : div_diff[XLEN-1:0]),
                acc_q[XLEN-2:0], ~div_diff[XLEN]};

    prod_fix = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = sa_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op_in;
          rd_d  = rd_addr_in;
          sa_d  = sa_in;
          sb_d  = sb_in;
          cnt_d = '0;
          if (op[2]) begin
            acc_d = {{XLEN{1'b0}}, mag_a};
            b_d   = mag_b;
          end else begin
            acc_d = {{XLEN{1'b0}}, mag_b};
            b_d   = mag_a;
          end
          if (op[2] && (rs2_data == '0)) begin
            result_d = op[1] ? rs1_data : '1;
            state_d  = ST_DONE;
          end else if (op[2] && !op[0] && (rs1_data == MIN_NEG) && (rs2_data == '1)) begin
            result_d = op[1] ? '0 : MIN_NEG;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        unique case (op_q)
          OP_MUL:                      result_d = prod_fix[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:             result_d = quo_fix;
          default:                     result_d = rem_fix;
        endcase
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign rd_addr_out = rd_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative: results, latency, handshake, reset abort.
module tb_mdu_iterative;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  int n_cmp;
  int n_err;

  mdu_iterative #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rd_addr_in (rd_addr_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .rd_addr_out(rd_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request in the current (negedge-aligned) cycle; it is accepted at the next edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    start      = 1'b1;
    op         = o;
    rs1_data   = a;
    rs2_data   = b;
    rd_addr_in = rd;
    @(posedge clk);
    #1;
    start      = 1'b0;
    rs1_data   = 32'hDEAD_BEEF;
    rs2_data   = 32'h0BAD_F00D;
    rd_addr_in = 5'd31;
  endtask

  // Bounded wait for done; lat = cycles after the accept edge, -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = -1;
    busy_cyc = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                     input int exp_lat);
    int lat, bc;
    @(negedge clk);
    issue(o, a, b, rd);
    wait_done(lat, bc);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp);
    check({tag, "_rd"}, 32'(rd_addr_out), 32'(rd));
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int lat, bc, ndone;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b0;
    start      = 1'b0;
    op         = 3'b000;
    rs1_data   = '0;
    rs2_data   = '0;
    rd_addr_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rd_addr_out), 32'd0);
    rst = 1'b1;

    // MUL with busy-length check
    @(negedge clk);
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    wait_done(lat, bc);
    check("mul_lat", lat, 32'd34);
    check("mul_busy_cycles", bc, 32'd34);
    check("mul_res", result, 32'hFFFF_FFEB);
    check("mul_rd", 32'(rd_addr_out), 32'd5);

    run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 34);
    run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34);
    run("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 34);
    run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 34);
    run("divu",   3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        34);
    run("remu",   3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         34);
    run("divu0",  3'b101, 32'd100,       32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    run("rem0",   3'b110, 32'h0000_1234, 32'd0,         5'd14, 32'h0000_1234, 1);
    run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1);

    // Starts while busy (mid-calc and in the DONE cycle) must be ignored
    @(negedge clk);
    issue(3'b101, 32'd10, 32'd3, 5'd9);
    lat   = -1;
    ndone = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        lat = cyc;
        break;
      end
      if (cyc == 5) issue(3'b000, 32'd2, 32'd2, 5'd1);
    end
    check("ign_lat", lat, 32'd34);
    check("ign_res", result, 32'd3);
    check("ign_rd", 32'(rd_addr_out), 32'd9);
    issue(3'b000, 32'd2, 32'd2, 5'd1);
    @(negedge clk);
    check("ign_done_start", {30'd0, busy, done}, 32'd0);
    check("ign_single_done", ndone, 32'd1);
    check("ign_res_hold", result, 32'd3);
    // First IDLE cycle after DONE: accepted
    issue(3'b000, 32'd2, 32'd2, 5'd1);
    wait_done(lat, bc);
    check("after_lat", lat, 32'd34);
    check("after_res", result, 32'd4);
    check("after_rd", 32'(rd_addr_out), 32'd1);

    // Reset mid-operation aborts without a done pulse
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd5, 5'd20);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy_done", {30'd0, busy, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd", 32'(rd_addr_out), 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);
    run("post_rst", 3'b000, 32'd3, 32'd5, 5'd21, 32'd15, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the two register-file read operands (rs1/rs2 data) and produces a 32-bit writeback value plus destination address for the register-file write port.
- Multi-cycle with a start/busy/done handshake; the pipeline stalls on busy.
- Radix-2: one multiply bit or one divide bit per clock.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  request; accepted only when busy=0
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  operand A (dividend / multiplicand)
rs2_data  input  XLEN  operand B (divisor / multiplier)
rd_addr_in  input  5  destination register, captured on accept
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse; result and rd_addr_out are valid that cycle
result  output  XLEN  writeback data; held until the next accept
rd_addr_out  output  5  captured rd_addr_in; held until the next accept

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE; busy=0, done=0, result=0, rd_addr_out=0.
  - All internal registers are cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, CALC, FIX, DONE. busy = (state != IDLE); done = (state == DONE).
- IDLE: on start=1, latch op, rd_addr_in, operand magnitudes and sign flags (signedness per op); clear the iteration counter.
  - Normal op: go to CALC.
  - Early-out case: go directly to DONE with result loaded.
- CALC: one iteration per cycle, counter 0..XLEN-1; after the iteration with counter=XLEN-1, go to FIX.
  - Multiply: shift-add over |A|,|B| into a 2*XLEN accumulator.
  - Divide: restoring division of |A| by |B|, producing quotient and remainder magnitudes.
- FIX: apply sign correction, select the result word, register it into result; go to DONE.
  - MUL: low word. MULH/MULHSU/MULHU: high word.
  - Product sign = sA^sB. Quotient sign = sA^sB. Remainder sign = sA.
  - MULHSU treats B as unsigned.
- DONE: lasts exactly one cycle, then IDLE.
- Latency, normal ops: accept edge E0; done is high in the cycle following edge E0+XLEN+1, which is 34 cycles after the accept cycle at XLEN=32.
- Latency, early-out: done is high in the cycle immediately after the accept edge.
- Early-out cases (RISC-V defined results, no trap):
  - Divide by zero: DIV/DIVU quotient = all-ones; REM/REMU result = rs1_data.
  - Signed overflow (DIV with A = 0x80000000, B = 0xFFFFFFFF): quotient = 0x80000000; REM result = 0.
- Handshake:
  - start while busy=1 (including the DONE cycle) is ignored; inputs are not re-sampled.
  - start may be asserted in the first IDLE cycle after DONE.
  - Inputs need only be valid in the accept cycle.
- Arithmetic width:
  - Magnitudes are XLEN bits (|0x80000000| = 0x80000000 as unsigned).
  - Multiply accumulator is 2*XLEN; divide partial remainder is XLEN+1 bits.
  - Negation is two's complement, modulo width.
- The block never writes rd=x0 specially; the register file discards it.

Decomposition:
- Package mdu_pkg holds:
  - XLEN constant.
  - mdu_op_e enum (3-bit, funct3 values above).
  - mdu_state_e enum (IDLE, CALC, FIX, DONE).
  - Helper function is_signed_a(op) / is_signed_b(op).
- Single module; no sub-module required. Multiply and divide share the accumulator and counter registers.

Test Plan:
- MUL, A=7, B=0xFFFFFFFD (-3), rd=5 -> done at cycle 34 after accept; result=0xFFFFFFEB; rd_addr_out=5; busy high for 34 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7,2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100,7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF, done 1 cycle after accept. REM 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Start DIVU 10/3, then pulse start with MUL 2x2 at cycle 5 and again in the DONE cycle -> both ignored; result=3 and exactly one done pulse. A start in the following IDLE cycle is accepted.
- Start MUL, deassert rst at cycle 10 for one cycle -> busy, done, result and rd_addr_out are 0 immediately. After release, no done pulse appears; a new start completes normally.
